// File: rtl/half_sub_ripple_reg.sv
// Registered ripple-borrow subtractor, two half-subtractor cells per bit.
// Optional HALF_SUB_SATURATE_EN: clamp diff to 0 on underflow.
module half_sub_ripple_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [WIDTH-1:0] bit_borrow
);

  // {borrow, diff} of one half-subtractor cell
  function automatic logic [1:0] hsub(
    input logic x,
    input logic y
  );
    return {~x & y, x ^ y};
  endfunction

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] p1;
  logic [WIDTH-1:0] p2;
  logic [WIDTH-1:0] d_c;
  logic [WIDTH-1:0] d_nx;

  assign c[0] = borrow_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {p1[i], d1[i]}  = hsub(a[i], b[i]);
    assign {p2[i], d_c[i]} = hsub(d1[i], c[i]);
    assign c[i+1] = p1[i] | p2[i];
  end

`ifdef HALF_SUB_SATURATE_EN
  assign d_nx = c[WIDTH] ? '0 : d_c;
`else
  assign d_nx = d_c;
`endif

  // Result regs hold when idle; only out_valid follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      bit_borrow <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff       <= d_nx;
        borrow_out <= c[WIDTH];
        bit_borrow <= c[WIDTH:1];
      end
    end
  end

endmodule

// File: tb/tb_half_sub_ripple_reg.sv
// Random + directed bench for half_sub_ripple_reg at WIDTH 4 and 1.
// Reference model uses plain integer subtraction.
module tb_half_sub_ripple_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       bin = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;

  logic       ov4, bo4, ov1, bo1;
  logic [3:0] d4, bb4;
  logic [0:0] d1, bb1;

  logic       e_ov = 1'b0;
  logic [3:0] e_d4 = '0, e_bb4 = '0;
  logic       e_bo4 = 1'b0;
  logic [0:0] e_d1 = '0, e_bb1 = '0;
  logic       e_bo1 = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  half_sub_ripple_reg #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a4), .b(b4), .borrow_in(bin),
    .out_valid(ov4), .diff(d4),
    .borrow_out(bo4), .bit_borrow(bb4)
  );

  half_sub_ripple_reg #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a1), .b(b1), .borrow_in(bin),
    .out_valid(ov1), .diff(d1),
    .borrow_out(bo1), .bit_borrow(bb1)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ov4"}, 32'(ov4), 32'(e_ov));
    chk({tag, ".d4"},  32'(d4),  32'(e_d4));
    chk({tag, ".bo4"}, 32'(bo4), 32'(e_bo4));
    chk({tag, ".bb4"}, 32'(bb4), 32'(e_bb4));
    chk({tag, ".ov1"}, 32'(ov1), 32'(e_ov));
    chk({tag, ".d1"},  32'(d1),  32'(e_d1));
    chk({tag, ".bo1"}, 32'(bo1), 32'(e_bo1));
    chk({tag, ".bb1"}, 32'(bb1), 32'(e_bb1));
  endtask

  task automatic model_clear();
    e_ov = 0; e_d4 = 0; e_bo4 = 0; e_bb4 = 0;
    e_d1 = 0; e_bo1 = 0; e_bb1 = 0;
  endtask

  // Reference: arithmetic on integers; the borrow out of bit i is
  // whether the low (i+1) bits of a are below those of b plus bin.
  task automatic model_load(
    input int av, input int bv, input int ci, input int w,
    output logic [3:0] d, output logic bo, output logic [3:0] bb
  );
    int full, m;
    full = av - bv - ci;
    d  = 4'(full & ((1 << w) - 1));
    bo = (full < 0);
    bb = '0;
    for (int i = 0; i < w; i++) begin
      m = (2 << i) - 1;
      bb[i] = ((av & m) < ((bv & m) + ci));
    end
`ifdef HALF_SUB_SATURATE_EN
    if (bo) d = '0;
`endif
  endtask

  task automatic step(
    input string tag, input logic v,
    input logic [3:0] av, input logic [3:0] bv,
    input logic ci, input logic a1v, input logic b1v
  );
    logic [3:0] d, bb;
    logic bo;
    @(negedge clk);
    in_valid = v; a4 = av; b4 = bv; bin = ci; a1 = a1v; b1 = b1v;
    @(posedge clk);
    e_ov = v;
    if (v) begin
      model_load(int'(av), int'(bv), int'(ci), 4, d, bo, bb);
      e_d4 = d; e_bo4 = bo; e_bb4 = bb;
      model_load(int'(a1v), int'(b1v), int'(ci), 1, d, bo, bb);
      e_d1 = d[0:0]; e_bo1 = bo; e_bb1 = bb[0:0];
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // reset held with active random inputs
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1; a4 = 4'($urandom); b4 = 4'($urandom);
      bin = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      @(posedge clk); #1;
      model_clear();
      check_all("rst_hold");
    end
    @(negedge clk);
    rst_n = 1;

    step("sub_9_3",  1, 4'h9, 4'h3, 0, 0, 0);
    chk("sub_9_3.exact_d", 32'(d4), 32'h6);
    step("sub_3_9",  1, 4'h3, 4'h9, 0, 0, 1);
    step("sub_0_0_1", 1, 4'h0, 4'h0, 1, 0, 0);
    chk("wrap.bb", 32'(bb4), 32'hF);
    chk("wrap.bo", 32'(bo4), 32'h1);
    step("sub_0_F",  1, 4'h0, 4'hF, 0, 1, 0);
    step("sub_eq",   1, 4'hA, 4'hA, 0, 1, 1);
    chk("eq.d", 32'(d4), 32'h0);

    // WIDTH=1 truth table
    step("tt00", 1, 4'h0, 4'h0, 0, 0, 0);
    step("tt01", 1, 4'h0, 4'h0, 0, 0, 1);
    step("tt10", 1, 4'h0, 4'h0, 0, 1, 0);
    step("tt11", 1, 4'h0, 4'h0, 0, 1, 1);

    // hold: single valid then idle with junk inputs
    step("hold0", 1, 4'h5, 4'h1, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      step("hold", 0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("hold.d", 32'(d4), 32'h4);

    // back-to-back
    step("b2b_7_2", 1, 4'h7, 4'h2, 0, 1, 0);
    step("b2b_2_7", 1, 4'h2, 4'h7, 0, 0, 1);

    // mid-cycle async reset discards result
    step("pre_rst", 1, 4'hC, 4'h1, 0, 1, 0);
    @(negedge clk);
    in_valid = 1; a4 = 4'hE; b4 = 4'h3;
    #2;
    rst_n = 0;
    #1;
    model_clear();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("async_rst_hold");
    @(negedge clk);
    rst_n = 1;

    // random traffic
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
